// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared widths, FSM state codes and helpers for the IF-stage
//             fetch sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int WORD_W     = 32;
  localparam int IMEM_IDX_W = 12;

  localparam logic [WORD_W-1:0] NOP_WORD_DEF = '0;

  // Sequencer states; encoding is fixed so external debug tools can decode it
  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Full word index of a byte address (all upper bits kept so range checks
  // cannot alias into the memory window)
  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] byte_addr);
    return {2'b00, byte_addr[WORD_W-1:2]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_next.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pc_next
//  Brief    : Combinational next-PC select: branch target (word aligned),
//             hold on stall, or sequential PC+4.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic              branch_taken,
  input  logic              stall,
  input  logic [WORD_W-1:0] branch_target,
  output logic [WORD_W-1:0] pc_plus_four,
  output logic [WORD_W-1:0] pc_next
);

  assign pc_plus_four = pc + 32'd4;

  // Branch beats stall; the target's low bits are dropped to keep PC aligned
  always_comb begin
    pc_next = pc_plus_four;
    if (branch_taken) begin
      pc_next = {branch_target[WORD_W-1:2], 2'b00};
    end else if (stall) begin
      pc_next = pc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Brief    : MIPS IF-stage owner of PC and the instruction memory port.
//             Loads a program, fetches with stall/branch handling, drains
//             the pipeline and halts on request or on a fetch fault.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                IMEM_DEPTH   = 4000,
  parameter logic [WORD_W-1:0] RESET_PC     = '0,
  parameter int                DRAIN_CYCLES = 4,
  parameter logic [WORD_W-1:0] NOP_WORD     = NOP_WORD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [WORD_W-1:0]     load_addr,
  input  logic [WORD_W-1:0]     load_data,
  output logic                  load_ready,
  output logic                  load_err,
  input  logic                  run_start,
  input  logic                  halt_req,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [WORD_W-1:0]     branch_target,
  output logic [IMEM_IDX_W-1:0] imem_addr,
  output logic                  imem_we,
  output logic [WORD_W-1:0]     imem_wdata,
  input  logic [WORD_W-1:0]     imem_rdata,
  output logic [WORD_W-1:0]     if_instruction,
  output logic [WORD_W-1:0]     if_pc_plus_four,
  output logic                  if_valid,
  output logic [WORD_W-1:0]     pc,
  output logic                  fault,
  output logic [WORD_W-1:0]     fetch_count
);

  localparam int                DRAIN_W    = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [WORD_W-1:0]  DEPTH_WORDS = WORD_W'(IMEM_DEPTH);

  logic [1:0]         state_q, state_d;
  logic [WORD_W-1:0]  pc_q, pc_d;
  logic               load_err_q, load_err_d;
  logic               fault_q, fault_d;
  logic [WORD_W-1:0]  fetch_count_q, fetch_count_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

  logic [WORD_W-1:0]  pc_next;
  logic [WORD_W-1:0]  pc_plus_four;
  logic               pc_oob;
  logic               load_in_range;
  logic [DRAIN_W-1:0] drain_inc;

  assign pc_oob        = word_index(pc_q) >= DEPTH_WORDS;
  assign load_in_range = word_index(load_addr) < DEPTH_WORDS;
  assign drain_inc     = drain_cnt_q + DRAIN_W'(1);

  fetch_pc_next u_pc_next (
    .pc            (pc_q),
    .branch_taken  (branch_taken),
    .stall         (stall),
    .branch_target (branch_target),
    .pc_plus_four  (pc_plus_four),
    .pc_next       (pc_next)
  );

  // Memory port mux and IF/ID handshake; reset masks every side effect
  always_comb begin
    load_ready = 1'b0;
    imem_we    = 1'b0;
    imem_wdata = load_data;
    imem_addr  = pc_q[IMEM_IDX_W+1:2];
    if_valid   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        imem_addr  = load_addr[IMEM_IDX_W+1:2];
        imem_we    = load_valid && load_in_range;
      end
      ST_RUN: begin
        if_valid = !pc_oob && !branch_taken;
      end
      default: begin
      end
    endcase
    if (rst) begin
      load_ready = 1'b0;
      imem_we    = 1'b0;
      if_valid   = 1'b0;
    end
  end

  assign if_instruction  = if_valid ? imem_rdata : NOP_WORD;
  assign if_pc_plus_four = pc_plus_four;
  assign pc              = pc_q;
  assign load_err        = load_err_q;
  assign fault           = fault_q;
  assign fetch_count     = fetch_count_q;

  // Next-state, PC, sticky flags and counters
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    load_err_d    = load_err_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;
    drain_cnt_d   = '0;
    case (state_q)
      ST_LOAD: begin
        // Out-of-range words are still accepted, only the write is dropped
        if (load_valid && !load_in_range) begin
          load_err_d = 1'b1;
        end
        if (run_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pc_oob) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          pc_d = pc_next;
          if (!branch_taken && !stall && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + 32'd1;
          end
          if (halt_req) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_inc;
        if (drain_inc >= DRAIN_LAST) begin
          state_d = ST_HALT;
        end
      end
      default: begin
        // HALT: resume wins over a new load; the triggering load word is not taken
        if (run_start) begin
          state_d = ST_RUN;
        end else if (load_valid) begin
          state_d = ST_LOAD;
          pc_d    = RESET_PC;
        end
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      pc_q          <= RESET_PC;
      load_err_q    <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
      drain_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      load_err_q    <= load_err_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
      drain_cnt_q   <= drain_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Brief    : Directed self-checking bench for fetch_sequencer with a
//             behavioural asynchronous-read instruction memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_err;
  logic        run_start;
  logic        halt_req;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [11:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_plus_four;
  logic        if_valid;
  logic [31:0] pc;
  logic        fault;
  logic [31:0] fetch_count;

  int n_cmp;
  int n_mis;

  logic [31:0] mem [0:4095];

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .load_valid      (load_valid),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .load_err        (load_err),
    .run_start       (run_start),
    .halt_req        (halt_req),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_addr       (imem_addr),
    .imem_we         (imem_we),
    .imem_wdata      (imem_wdata),
    .imem_rdata      (imem_rdata),
    .if_instruction  (if_instruction),
    .if_pc_plus_four (if_pc_plus_four),
    .if_valid        (if_valid),
    .pc              (pc),
    .fault           (fault),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: synchronous write, asynchronous read
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
  end
  assign imem_rdata = mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    rst = 1'b1; load_valid = 1'b1; load_addr = 32'h0; load_data = 32'hDEAD;
    run_start = 1'b0; halt_req = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;

    // ---- reset state, loader masked while rst is high
    tick(); tick();
    chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
    chk("rst_imem_we", {31'b0, imem_we}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_load_err", {31'b0, load_err}, 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_state", {30'b0, dut.state_q}, 32'd0);

    // ---- load program
    rst = 1'b0; load_addr = 32'h0; load_data = 32'h11; #1;
    chk("load_ready", {31'b0, load_ready}, 32'd1);
    chk("load_we", {31'b0, imem_we}, 32'd1);
    chk("mem0_not_written_in_rst", mem[0], 32'h0);
    tick();
    load_word(32'h4, 32'h22);
    load_word(32'h8, 32'h33);
    load_word(32'hC, 32'h44);
    load_valid = 1'b0; run_start = 1'b1;
    tick();
    run_start = 1'b0; #1;

    // ---- sequential fetch
    chk("run_state", {30'b0, dut.state_q}, 32'd1);
    chk("instr0", if_instruction, 32'h11);
    chk("ppf0", if_pc_plus_four, 32'd4);
    chk("valid0", {31'b0, if_valid}, 32'd1);
    tick();
    chk("instr1", if_instruction, 32'h22);
    chk("ppf1", if_pc_plus_four, 32'd8);
    tick();
    chk("instr2", if_instruction, 32'h33);
    chk("ppf2", if_pc_plus_four, 32'd12);
    chk("count2", fetch_count, 32'd2);

    // ---- two stall cycles at pc=8
    stall = 1'b1; #1;
    chk("stall_valid_a", {31'b0, if_valid}, 32'd1);
    tick();
    chk("stall_pc_a", pc, 32'd8);
    chk("stall_valid_b", {31'b0, if_valid}, 32'd1);
    chk("stall_instr_b", if_instruction, 32'h33);
    tick();
    stall = 1'b0; #1;
    chk("stall_pc_b", pc, 32'd8);
    chk("stall_count", fetch_count, 32'd2);
    tick();
    chk("after_stall_pc", pc, 32'd12);
    chk("after_stall_count", fetch_count, 32'd3);

    // ---- branch with simultaneous stall, misaligned target
    branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h43; #1;
    chk("br_valid", {31'b0, if_valid}, 32'd0);
    chk("br_nop", if_instruction, 32'h0);
    tick();
    branch_taken = 1'b0; stall = 1'b0; #1;
    chk("br_pc", pc, 32'h40);
    chk("br_count", fetch_count, 32'd3);

    // ---- halt request, drain ignores branch/halt_req
    halt_req = 1'b1; #1;
    chk("halt_cycle_valid", {31'b0, if_valid}, 32'd1);
    tick();
    branch_taken = 1'b1; branch_target = 32'h100;
    chk("drain_pc", pc, 32'h44);
    chk("drain_count", fetch_count, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'b0, if_valid}, 32'd0);
      chk("drain_state", {30'b0, dut.state_q}, 32'd2);
      tick();
    end
    halt_req = 1'b0; branch_taken = 1'b0; #1;
    chk("halt_state", {30'b0, dut.state_q}, 32'd3);
    chk("halt_pc", pc, 32'h44);
    chk("halt_valid", {31'b0, if_valid}, 32'd0);
    chk("halt_load_ready", {31'b0, load_ready}, 32'd0);
    run_start = 1'b1;
    tick();
    run_start = 1'b0; #1;
    chk("resume_state", {30'b0, dut.state_q}, 32'd1);
    chk("resume_pc", pc, 32'h44);

    // ---- reset in the middle of a drain
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    chk("mid_drain_state", {30'b0, dut.state_q}, 32'd2);
    rst = 1'b1; load_valid = 1'b1; load_addr = 32'h0; load_data = 32'hBAD; #1;
    chk("rst_drain_we", {31'b0, imem_we}, 32'd0);
    tick();
    rst = 1'b0; load_valid = 1'b0; #1;
    chk("rst_drain_state", {30'b0, dut.state_q}, 32'd0);
    chk("rst_drain_pc", pc, 32'd0);
    chk("rst_drain_count", fetch_count, 32'd0);
    chk("rst_drain_mem0", mem[0], 32'h11);

    // ---- out-of-range load, then reset mid-load
    load_valid = 1'b1; load_addr = 32'd16000; load_data = 32'h5; #1;
    chk("oob_we", {31'b0, imem_we}, 32'd0);
    chk("oob_ready", {31'b0, load_ready}, 32'd1);
    tick();
    load_valid = 1'b0; #1;
    chk("oob_load_err", {31'b0, load_err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rst_load_state", {30'b0, dut.state_q}, 32'd0);
    chk("rst_load_err_clr", {31'b0, load_err}, 32'd0);

    // ---- fill memory, fetch off the end
    for (int i = 0; i < 4000; i++) begin
      load_valid = 1'b1; load_addr = 32'(i) * 32'd4; load_data = 32'(i) + 32'h100;
      if (i == 3999) begin
        #1;
        chk("last_word_we", {31'b0, imem_we}, 32'd1);
      end
      tick();
    end
    load_valid = 1'b0; run_start = 1'b1;
    tick();
    run_start = 1'b0; branch_taken = 1'b1; branch_target = 32'd15984;
    tick();
    branch_taken = 1'b0; #1;
    chk("edge_pc", pc, 32'd15984);
    chk("edge_instr", if_instruction, 32'd3996 + 32'h100);
    tick(); tick(); tick();
    chk("last_instr", if_instruction, 32'd3999 + 32'h100);
    chk("last_count", fetch_count, 32'd3);
    tick();
    chk("oob_pc", pc, 32'd16000);
    chk("oob_valid", {31'b0, if_valid}, 32'd0);
    chk("oob_nop", if_instruction, 32'h0);
    chk("oob_fault_pending", {31'b0, fault}, 32'd0);
    tick();
    chk("fault_set", {31'b0, fault}, 32'd1);
    chk("fault_state", {30'b0, dut.state_q}, 32'd3);
    chk("fault_pc_frozen", pc, 32'd16000);
    chk("fault_count", fetch_count, 32'd4);

    // ---- load request from HALT returns to LOAD without writing
    load_valid = 1'b1; load_addr = 32'h0; load_data = 32'h77; #1;
    chk("halt_load_we", {31'b0, imem_we}, 32'd0);
    tick();
    load_valid = 1'b0; #1;
    chk("reload_state", {30'b0, dut.state_q}, 32'd0);
    chk("reload_pc", pc, 32'd0);
    chk("reload_mem0", mem[0], 32'h100);
    chk("reload_fault_sticky", {31'b0, fault}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
